// File: rtl/store_buffer.sv
// Store buffer between the EX/MEM pipeline register and the single-port data
// memory. Stores are queued and retired in cycles where the MEM stage issues no
// request. Loads use the port immediately and are forwarded from the queue on an
// address match.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     req_ready,
    output logic                     ld_valid,
    output logic [DATA_W-1:0]        ld_data,
    input  logic                     drain_req,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] entryAddr [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];

    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  occCount;

    logic              isEmpty;
    logic              isFull;
    logic              anyHit;
    logic [PTR_W-1:0]  hitIdx;
    logic [PTR_W-1:0]  slotOffset;
    logic              drainCycle;
    logic              reqReady;
    logic              storeAcc;
    logic              loadAcc;

    // Status is derived purely from the occupancy register, so it never
    // depends on the current request.
    assign isEmpty = (occCount == '0);
    assign isFull  = (occCount == CNT_W'(DEPTH));
    assign count   = occCount;
    assign empty   = isEmpty;
    assign full    = isFull;

    // A forced drain holds off new requests until the queue is empty, which
    // also keeps stores and retirements from ever sharing a cycle.
    assign reqReady   = !isFull && !(drain_req && !isEmpty);
    assign drainCycle = !isEmpty && (!req_valid || isFull || drain_req);
    assign storeAcc   = req_valid && req_write && reqReady;
    assign loadAcc    = req_valid && !req_write && reqReady;
    assign req_ready  = reqReady;

    // Find the occupied entry whose address equals the request address
    always_comb begin
        anyHit     = 1'b0;
        hitIdx     = '0;
        slotOffset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Distance from head tells whether slot i currently holds a store.
            slotOffset = PTR_W'(i) - headPtr;
            if (({1'b0, slotOffset} < occCount) && (entryAddr[i] == req_addr)) begin
                anyHit = 1'b1;
                hitIdx = PTR_W'(i);
            end
        end
    end

    // Drive the memory port and the load result
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        if (loadAcc) begin
            mem_re   = 1'b1;
            mem_addr = req_addr;
            ld_valid = 1'b1;
            ld_data  = anyHit ? entryData[hitIdx] : mem_rdata;
        end else if (drainCycle) begin
            mem_we    = 1'b1;
            mem_addr  = entryAddr[headPtr];
            mem_wdata = entryData[headPtr];
        end
    end

    // Advance pointers and occupancy on retirement or on a non-coalescing store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            occCount <= '0;
        end else if (drainCycle) begin
            headPtr  <= headPtr + PTR_W'(1);
            occCount <= occCount - CNT_W'(1);
        end else if (storeAcc && !anyHit) begin
            tailPtr  <= tailPtr + PTR_W'(1);
            occCount <= occCount + CNT_W'(1);
        end
    end

    // Entry storage: coalesce into a matching entry, else append at tail
    always_ff @(posedge clk) begin
        if (storeAcc) begin
            if (anyHit) begin
                entryData[hitIdx] <= req_wdata;
            end else begin
                entryAddr[tailPtr] <= req_addr;
                entryData[tailPtr] <= req_wdata;
            end
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-deferral buffer between the EX/MEM pipeline register and the data memory. Stores are queued in a small FIFO and retired to memory only in cycles where the MEM stage issues no request. Loads get the single memory port immediately. A load whose address matches a queued store is forwarded from the buffer, so program order is preserved.

## Interface
- `DEPTH`, 4: number of store entries; a power of two, 2..16.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  MEM stage has a memory operation this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  ALU-computed address.
- `req_wdata`  in  DATA_W  store data.
- `req_ready`  out  1  request accepted this cycle; 0 stalls the pipeline.
- `ld_valid`  out  1  load accepted; `ld_data` is valid this cycle.
- `ld_data`  out  DATA_W  load result, either forwarded or from memory.
- `drain_req`  in  1  force retirement (halt/syscall); level-sensitive.
- `mem_we`  out  1  memory write enable.
- `mem_re`  out  1  memory read enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid in the same cycle as `mem_addr`; memory samples on negedge.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `empty`, `full`  out  1  status flags.

## Operation
- **State**
  - Circular FIFO of {addr, data} with head/tail pointers.
  - Pointers wrap modulo DEPTH; `count` is kept separately.
- **drain_cycle** = !empty && (!req_valid || full || drain_req).
- **req_ready** = !full && !(drain_req && !empty).
  - Stores and drains therefore never occur in the same cycle.
- **Store accepted** (req_valid & req_write & req_ready):
  - If any entry has an equal addr, its data is overwritten in place (coalesce); count is unchanged.
  - Otherwise {req_addr, req_wdata} is written at tail; tail and count are incremented.
  - Full 16-bit address compare.
  - `mem_we`=0 and `mem_re`=0.
- **Load accepted** (req_valid & !req_write & req_ready):
  - `mem_re`=1, `mem_addr`=req_addr, `ld_valid`=1.
  - On an address match, `ld_data` is the matching entry's data. Coalescing guarantees at most one match.
  - Otherwise `ld_data`=`mem_rdata`.
- **Drain cycle**:
  - `mem_we`=1, `mem_addr`/`mem_wdata` = head entry, `mem_re`=0.
  - Head is incremented and count decremented at posedge.
- **Idle** (no request, empty):
  - All `mem_*` enables are 0.
  - `mem_addr`/`mem_wdata` are 0.
  - `ld_data` is 0.
- **Not-ready request**: no state change, `ld_valid`=0, and the request must be held by upstream.

## Timing
- **Reset**: pointers 0, count 0, `empty`=1, `full`=0, `req_ready`=1 (when `drain_req`=0), all `mem_*` and `ld_*` outputs 0. Entry contents are don't-care.
- **Output paths**:
  - `mem_*`, `req_ready` and `ld_*` are combinational from current state and request inputs.
  - `count`, `empty` and `full` are registered.
- **Load latency**: 0 cycles. Data appears in the cycle of acceptance (memory read at negedge).
- **Store retirement**: earliest one cycle after acceptance, in the first drain_cycle.
- **Forwarding visibility**: covers entries written at earlier posedges only.
- **Full + request**: `req_ready`=0, the head drains that cycle, and the request is accepted the next cycle.
- **drain_req**:
  - Stalls requests and drains one entry per cycle until empty.
  - `req_ready` returns to 1 in the cycle `empty`=1.
- **Reset mid-drain**: pending entries are discarded and are never written. Asserting `rst_n` low during a drain cycle drops `mem_we` immediately (asynchronous).

## Test plan
- **Reset**: after reset, `count`=0, `empty`=1, `mem_we`=0; a load of addr 5 with `mem_rdata`=0x0007 gives `ld_valid`=1, `ld_data`=0x0007, `mem_re`=1.
- **Store then idle**: store 0x1234 to addr 6, then an idle cycle.
  - Store cycle: `mem_we`=0.
  - Next cycle: `mem_we`=1, `mem_addr`=6, `mem_wdata`=0x1234; `empty`=1 after that cycle.
- **Forward from buffer**: stores to addr 12 (0x0001) and addr 7 (0x0004), then a load of addr 7 without idling. Required: `ld_data`=0x0004 even though `mem_rdata`=0xFFFF; `count` stays 2.
- **Coalesce**: store addr 8 = 0xAAAA, then addr 8 = 0xBBBB. Required: `count`=1; the next drain writes 0xBBBB; only one `mem_we` pulse occurs.
- **Fill and stall**: 4 back-to-back stores to distinct addresses, followed by a fifth.
  - `full`=1 after the fourth; the fifth sees `req_ready`=0.
  - The head (first address) drains that cycle; the fifth is accepted the next cycle with `count`=4.
- **Forced drain and reset**:
  - 3 queued entries plus `drain_req`=1: `req_ready`=0 for 3 cycles, 3 writes in FIFO order, then `req_ready`=1.
  - Repeat with `rst_n` pulsed low on the second write: `mem_we` drops immediately and `count`=0.
